// File: rtl/e_muldiv.sv
// ---------------------------------------------------------------------------
// e_muldiv -- execute-stage multiply/divide unit with architectural HI/LO.
//
// Sits beside the E-stage ALU and decodes the instruction held in E. It
// handles mult/multu/div/divu with a fixed multi-cycle latency, mthi/mtlo
// writes, and mfhi/mflo reads.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu   (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, clears all state
//   E_inStr    instruction currently in E (0 = bubble)
//   E_RD1      forwarded rs value
//   E_RD2      forwarded rt value
//   E_mdStart  mul/div instruction in E while the unit is idle
//   E_mdBusy   an operation is in flight
//   E_mdOut    HI for mfhi, LO for mflo, otherwise 0
//   E_HI       current HI register
//   E_LO       current LO register
// ---------------------------------------------------------------------------
module e_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_inStr,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  output logic        E_mdStart,
  output logic        E_mdBusy,
  output logic [31:0] E_mdOut,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_pendHi;
  logic [31:0]   r_pendLo;
  logic          r_pendValid;

  logic        w_isR;
  logic [5:0]  w_funct;
  logic        w_isMult, w_isMultu, w_isDiv, w_isDivu;
  logic        w_isMfhi, w_isMflo, w_isMthi, w_isMtlo;
  logic        w_isMd;
  logic        w_unusedFields;

  logic [63:0] w_prodS, w_prodU;
  logic        w_divZero;
  logic [31:0] w_divisor;
  logic [31:0] w_absA, w_absB, w_qMag, w_rMag;
  logic [31:0] w_qS, w_rS, w_qU, w_rU;

  logic [31:0]   w_resHi, w_resLo;
  logic          w_resValid;
  logic [CW-1:0] w_cycles;

  // Decode: only opcode 0 (SPECIAL) carries the mul/div class functs.
  assign w_isR     = (E_inStr[31:26] == 6'd0);
  assign w_funct   = E_inStr[5:0];
  assign w_isMult  = w_isR && (w_funct == F_MULT);
  assign w_isMultu = w_isR && (w_funct == F_MULTU);
  assign w_isDiv   = w_isR && (w_funct == F_DIV);
  assign w_isDivu  = w_isR && (w_funct == F_DIVU);
  assign w_isMfhi  = w_isR && (w_funct == F_MFHI);
  assign w_isMflo  = w_isR && (w_funct == F_MFLO);
  assign w_isMthi  = w_isR && (w_funct == F_MTHI);
  assign w_isMtlo  = w_isR && (w_funct == F_MTLO);
  assign w_isMd    = w_isMult | w_isMultu | w_isDiv | w_isDivu;

  // Register fields of the instruction are irrelevant to this unit.
  assign w_unusedFields = ^E_inStr[25:6];

  // Signed product via sign-extended operands; the low 64 bits are exact.
  assign w_prodS = {{32{E_RD1[31]}}, E_RD1} * {{32{E_RD2[31]}}, E_RD2};
  assign w_prodU = {32'd0, E_RD1} * {32'd0, E_RD2};

  // Divide by a safe nonzero divisor so the datapath never produces X;
  // a zero divisor suppresses the final HI/LO write instead.
  assign w_divZero = (E_RD2 == 32'd0);
  assign w_divisor = w_divZero ? 32'd1 : E_RD2;

  // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to
  // 0x80000000 rather than hitting an overflow in a signed divider.
  assign w_absA = E_RD1[31]     ? (~E_RD1 + 32'd1)     : E_RD1;
  assign w_absB = w_divisor[31] ? (~w_divisor + 32'd1) : w_divisor;
  assign w_qMag = w_absA / w_absB;
  assign w_rMag = w_absA % w_absB;
  assign w_qS   = (E_RD1[31] ^ w_divisor[31]) ? (~w_qMag + 32'd1) : w_qMag;
  assign w_rS   = E_RD1[31] ? (~w_rMag + 32'd1) : w_rMag;
  assign w_qU   = E_RD1 / w_divisor;
  assign w_rU   = E_RD1 % w_divisor;

  always_comb begin
    w_resHi    = w_prodS[63:32];
    w_resLo    = w_prodS[31:0];
    w_resValid = 1'b1;
    w_cycles   = CW'(MULT_CYCLES);
    if (w_isMultu) begin
      w_resHi = w_prodU[63:32];
      w_resLo = w_prodU[31:0];
    end else if (w_isDiv) begin
      w_resHi    = w_rS;
      w_resLo    = w_qS;
      w_resValid = ~w_divZero;
      w_cycles   = CW'(DIV_CYCLES);
    end else if (w_isDivu) begin
      w_resHi    = w_rU;
      w_resLo    = w_qU;
      w_resValid = ~w_divZero;
      w_cycles   = CW'(DIV_CYCLES);
    end
  end

  // Control FSM: IDLE accepts mul/div starts and mt* writes; BUSY counts
  // down and commits the pending result on the last counted edge. Anything
  // arriving in E while BUSY is deliberately dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_pendHi    <= 32'd0;
      r_pendLo    <= 32'd0;
      r_pendValid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_isMd) begin
            r_pendHi    <= w_resHi;
            r_pendLo    <= w_resLo;
            r_pendValid <= w_resValid;
            r_cnt       <= w_cycles;
            r_state     <= S_BUSY;
          end else if (w_isMthi) begin
            r_hi <= E_RD1;
          end else if (w_isMtlo) begin
            r_lo <= E_RD1;
          end
        end
        S_BUSY: begin
          if (r_cnt == CW'(1)) begin
            if (r_pendValid) begin
              r_hi <= r_pendHi;
              r_lo <= r_pendLo;
            end
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign E_mdBusy  = (r_state == S_BUSY);
  assign E_mdStart = w_isMd & ~E_mdBusy;
  assign E_mdOut   = w_isMfhi ? r_hi : (w_isMflo ? r_lo : 32'd0);
  assign E_HI      = r_hi;
  assign E_LO      = r_lo;

endmodule

// File: tb/tb_e_muldiv.sv
// ---------------------------------------------------------------------------
// tb_e_muldiv -- directed self-checking bench for e_muldiv.
//
// Inputs are driven just after the falling edge and outputs are sampled
// 1 ns later, well away from the rising edge the DUT updates on. HI/LO
// expectations are hand-computed constants per vector.
// ---------------------------------------------------------------------------
module tb_e_muldiv;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] MULT  = 32'h0085_0018;
  localparam logic [31:0] MULTU = 32'h0085_0019;
  localparam logic [31:0] DIV   = 32'h0085_001A;
  localparam logic [31:0] DIVU  = 32'h0085_001B;
  localparam logic [31:0] MFHI  = 32'h0000_4010;
  localparam logic [31:0] MTHI  = 32'h0080_0011;
  localparam logic [31:0] MFLO  = 32'h0000_4012;
  localparam logic [31:0] MTLO  = 32'h0080_0013;
  localparam logic [31:0] LWLIKE = 32'h8C00_0018;

  logic        clk;
  logic        reset;
  logic [31:0] E_inStr;
  logic [31:0] E_RD1;
  logic [31:0] E_RD2;
  logic        E_mdStart;
  logic        E_mdBusy;
  logic [31:0] E_mdOut;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  int checkCount;
  int errorCount;

  e_muldiv #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .E_inStr   (E_inStr),
    .E_RD1     (E_RD1),
    .E_RD2     (E_RD2),
    .E_mdStart (E_mdStart),
    .E_mdBusy  (E_mdBusy),
    .E_mdOut   (E_mdOut),
    .E_HI      (E_HI),
    .E_LO      (E_LO)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
    end
  endtask

  // Drive one instruction for the current cycle and let combinational
  // outputs settle before any sampling.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] a,
                               input logic [31:0] b);
    E_inStr = instr;
    E_RD1   = a;
    E_RD2   = b;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Issue a mul/div in the current cycle, hold nops while busy, and check
  // busy timing plus the committed HI/LO. Returns in cycle n+1 so the
  // caller can issue the next op back-to-back.
  task automatic runOp(input string tag, input logic [31:0] instr,
                       input logic [31:0] a, input logic [31:0] b, input int n,
                       input logic [31:0] oldHi, input logic [31:0] oldLo,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    applyStimulus(instr, a, b);
    checkOutput({tag, " start"}, {31'd0, E_mdStart}, 32'd1);
    for (int i = 1; i <= n; i++) begin
      tick();
      applyStimulus(NOP, 32'd0, 32'd0);
      checkOutput({tag, " busy"}, {31'd0, E_mdBusy}, 32'd1);
      if (i == n) begin
        checkOutput({tag, " HI held"}, E_HI, oldHi);
        checkOutput({tag, " LO held"}, E_LO, oldLo);
      end
    end
    tick();
    applyStimulus(NOP, 32'd0, 32'd0);
    checkOutput({tag, " done"}, {31'd0, E_mdBusy}, 32'd0);
    checkOutput({tag, " HI"}, E_HI, expHi);
    checkOutput({tag, " LO"}, E_LO, expLo);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset   = 1'b1;
    E_inStr = NOP;
    E_RD1   = 32'd0;
    E_RD2   = 32'd0;
    repeat (2) tick();
    reset = 1'b0;
    applyStimulus(NOP, 32'd0, 32'd0);
    checkOutput("reset HI", E_HI, 32'd0);
    checkOutput("reset LO", E_LO, 32'd0);
    checkOutput("reset busy", {31'd0, E_mdBusy}, 32'd0);
    checkOutput("reset start", {31'd0, E_mdStart}, 32'd0);
    checkOutput("reset mdOut", E_mdOut, 32'd0);

    // Multiply, signed then unsigned, issued back-to-back.
    tick();
    runOp("mult", MULT, 32'hFFFF_FFFF, 32'd2, MULT_N,
          32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp("multu", MULTU, 32'hFFFF_FFFF, 32'd2, MULT_N,
          32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE);

    // Divide, signed then unsigned.
    runOp("div", DIV, 32'hFFFF_FFF9, 32'd2, DIV_N,
          32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu", DIVU, 32'd7, 32'd2, DIV_N,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);

    // mthi then mtlo on consecutive cycles, then reads.
    tick();
    applyStimulus(MTHI, 32'h0000_1234, 32'd0);
    tick();
    applyStimulus(MTLO, 32'h0000_5678, 32'd0);
    checkOutput("mthi HI", E_HI, 32'h0000_1234);
    tick();
    applyStimulus(MFHI, 32'd0, 32'd0);
    checkOutput("mtlo LO", E_LO, 32'h0000_5678);
    checkOutput("mfhi out", E_mdOut, 32'h0000_1234);
    applyStimulus(MFLO, 32'd0, 32'd0);
    checkOutput("mflo out", E_mdOut, 32'h0000_5678);
    applyStimulus(LWLIKE, 32'd3, 32'd4);
    checkOutput("nonzero opcode start", {31'd0, E_mdStart}, 32'd0);
    tick();
    applyStimulus(NOP, 32'd0, 32'd0);
    checkOutput("nonzero opcode busy", {31'd0, E_mdBusy}, 32'd0);

    // Divide by zero keeps HI/LO; overflow case wraps.
    runOp("div0", DIV, 32'd5, 32'd0, DIV_N,
          32'h0000_1234, 32'h0000_5678, 32'h0000_1234, 32'h0000_5678);
    runOp("divovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N,
          32'h0000_1234, 32'h0000_5678, 32'd0, 32'h8000_0000);

    // Mult with further mult/mt*/mflo held in E while busy.
    tick();
    applyStimulus(MULT, 32'd3, 32'd4);
    checkOutput("hold start", {31'd0, E_mdStart}, 32'd1);
    for (int i = 1; i <= MULT_N; i++) begin
      tick();
      case (i)
        1, 2:    applyStimulus(MULT, 32'd5, 32'd6);
        3:       applyStimulus(MTHI, 32'h0000_DEAD, 32'd0);
        4:       applyStimulus(MTLO, 32'h0000_BEEF, 32'd0);
        default: applyStimulus(MFLO, 32'd0, 32'd0);
      endcase
      checkOutput("hold busy", {31'd0, E_mdBusy}, 32'd1);
      checkOutput("hold start blocked", {31'd0, E_mdStart}, 32'd0);
      if (i == MULT_N) checkOutput("mflo while busy", E_mdOut, 32'h8000_0000);
    end
    tick();
    applyStimulus(MFLO, 32'd0, 32'd0);
    checkOutput("hold done", {31'd0, E_mdBusy}, 32'd0);
    checkOutput("hold HI", E_HI, 32'd0);
    checkOutput("hold LO", E_LO, 32'd12);
    checkOutput("hold mflo", E_mdOut, 32'd12);

    // Reset in cycle 3 of a divide, then an immediate fresh multiply.
    tick();
    applyStimulus(DIV, 32'd100, 32'd7);
    tick();
    applyStimulus(NOP, 32'd0, 32'd0);
    tick();
    applyStimulus(NOP, 32'd0, 32'd0);
    tick();
    reset = 1'b1;
    applyStimulus(NOP, 32'd0, 32'd0);
    checkOutput("pre-reset busy", {31'd0, E_mdBusy}, 32'd1);
    tick();
    reset = 1'b0;
    applyStimulus(NOP, 32'd0, 32'd0);
    checkOutput("abort busy", {31'd0, E_mdBusy}, 32'd0);
    checkOutput("abort HI", E_HI, 32'd0);
    checkOutput("abort LO", E_LO, 32'd0);
    runOp("post-reset mult", MULT, 32'hFFFF_FFF9, 32'd6, MULT_N,
          32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/e_muldiv.md
Name: e_muldiv

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Sits beside the E-stage ALU, directly downstream of the D→E pipeline register, and consumes its E_inStr/E_RD1/E_RD2 outputs.
- Handles mult, multu, div, divu, mthi, mtlo, mfhi and mflo with a fixed multi-cycle latency.
- Exposes start/busy so the hazard unit can stall later mul/div-class instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; clears all state
- E_inStr  input  32  instruction currently in E; 0 means bubble/nop
- E_RD1  input  32  forwarded rs value
- E_RD2  input  32  forwarded rt value
- E_mdStart  output  1  combinational: E_inStr is mult/multu/div/divu and E_mdBusy=0
- E_mdBusy  output  1  registered: operation in flight
- E_mdOut  output  32  combinational: HI for mfhi, LO for mflo, else 0
- E_HI  output  32  current HI register
- E_LO  output  32  current LO register

Behaviour:
- Decode:
  - Instructions are recognised only when opcode [31:26]=0.
  - funct 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo.
  - All other encodings, including 0x00000000, are no-ops for this block.
- Reset: E_HI=0, E_LO=0, E_mdBusy=0, internal counter=0, pending HI/LO=0. E_mdStart and E_mdOut follow the decode rules.
- Start edge (E_mdStart=1):
  - Compute the result from E_RD1/E_RD2 and latch it into pending HI/LO.
  - Load counter with MULT_CYCLES or DIV_CYCLES; set E_mdBusy=1.
  - E_HI/E_LO are not changed on this edge.
- mult: signed 32×32→64; HI=[63:32], LO=[31:0]. multu: same, unsigned.
- div (signed):
  - LO = quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu: unsigned quotient in LO, remainder in HI.
- Divisor 0 (div/divu): the unit still goes busy for DIV_CYCLES. At completion, E_HI/E_LO keep their prior values (no update).
- Busy phase:
  - Counter decrements on each edge while busy.
  - On the edge where counter=1: E_HI/E_LO ← pending, counter ← 0, E_mdBusy ← 0.
  - E_mdBusy stays high for exactly N cycles after the start edge. New HI/LO are visible in cycle start+N+1.
- mthi/mtlo:
  - When not busy: E_HI ← E_RD1 (mthi) or E_LO ← E_RD1 (mtlo) on that edge.
  - When busy: ignored.
- While busy, mult/div/mthi/mtlo in E are ignored: no restart, no counter change. The hazard unit is required to prevent this; the block must still be safe if it happens.
- mfhi/mflo: E_mdOut reflects the current registered E_HI/E_LO with no internal bypass. If presented while busy, the output returns the old value; the hazard unit stalls these.
- Completion edge plus mt* in the same cycle cannot occur, since mt* is ignored while busy.
- Reset mid-operation: the operation is aborted, pending result discarded, all registers go to 0 on that edge.
- Back-to-back: a new mult/div is accepted in the first cycle with E_mdBusy=0, i.e. the cycle right after the completion edge.

Test Plan:
- Reset, then mult with RD1=0xFFFFFFFF, RD2=2:
  - E_mdStart=1 in cycle 0; E_mdBusy=1 in cycles 1–5.
  - Cycle 6: E_HI=0xFFFFFFFF, E_LO=0xFFFFFFFE.
  - multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div RD1=0xFFFFFFF9 (-7), RD2=2:
  - Busy for 10 cycles.
  - Then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - divu 7/2 → LO=3, HI=1.
- mthi 0x1234, then mtlo 0x5678 on consecutive cycles:
  - E_HI=0x1234, E_LO=0x5678.
  - div with RD2=0 → busy 10 cycles, then HI/LO unchanged.
  - 0x80000000/-1 → LO=0x80000000, HI=0.
- mult issued, second mult and mthi held in E during busy:
  - No restart; E_mdStart=0 while busy.
  - Result from the first mult only; mthi has no effect.
  - mflo after completion: E_mdOut = LO.
- reset asserted in cycle 3 of a div:
  - Next cycle: E_mdBusy=0, HI=LO=0.
  - A fresh mult issued immediately afterwards completes normally.
